// File: rtl/hack_run_ctrl.sv
// Hack CPU run/boot controller: streams a length-prefixed image into ROM,
// sequences CPU reset/run, and parks the CPU when it hits its terminal self-jump.
module hack_run_ctrl #(
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_load,
  input  logic        cmd_run,
  input  logic        cmd_stop,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  input  logic [14:0] cpu_pc,
  input  logic        cpu_writeM,
  output logic        cpu_reset,
  output logic        mem_we,
  output logic [31:0] cycles_run,
  output logic        loaded,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_RUN_RST, S_RUN, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d, addr_q, addr_d, len_w;
  logic [7:0]  hi_q, hi_d, match_q, match_d;
  logic [14:0] pc_d1_q, pc_d1_d, pc_d2_q, pc_d2_d;
  logic [1:0]  hist_q, hist_d;
  logic        rom_we_q, rom_we_d, loaded_q, loaded_d, halted_q, halted_d, err_q, err_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [15:0] rom_wdata_q, rom_wdata_d;
  logic [31:0] cycles_q, cycles_d;
  logic        xfer;

  assign rx_ready   = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO};
  assign cpu_reset  = (state_q != S_RUN);
  assign mem_we     = (state_q == S_RUN) && cpu_writeM;
  assign xfer       = rx_valid && rx_ready;
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cycles_run = cycles_q;
  assign loaded     = loaded_q;
  assign halted     = halted_q;
  assign err        = err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    match_d     = match_q;
    pc_d1_d     = pc_d1_q;
    pc_d2_d     = pc_d2_q;
    hist_d      = hist_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cycles_d    = cycles_q;
    loaded_d    = loaded_q;
    halted_d    = halted_q;
    err_d       = err_q;
    len_w       = {len_q[15:8], rx_data};
    case (state_q)
      S_IDLE, S_HALT: begin
        if (cmd_stop) state_d = S_IDLE;
        else if (cmd_load) begin
          state_d  = S_LEN_HI;
          loaded_d = 1'b0;
          err_d    = 1'b0;
          halted_d = 1'b0;
        end else if (cmd_run) state_d = S_RUN_RST;
      end
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
        if (cmd_stop) begin
          state_d  = S_IDLE;
          loaded_d = 1'b0;
        end else if (xfer) begin
          case (state_q)
            S_LEN_HI: begin
              len_d[15:8] = rx_data;
              state_d     = S_LEN_LO;
            end
            S_LEN_LO: begin
              len_d = len_w;
              if (len_w == 16'd0) begin
                state_d  = S_IDLE;
                loaded_d = 1'b1;
              end else if (len_w > 16'h8000) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end else begin
                state_d = S_DATA_HI;
                addr_d  = 16'd0;
              end
            end
            S_DATA_HI: begin
              hi_d    = rx_data;
              state_d = S_DATA_LO;
            end
            default: begin
              rom_we_d    = 1'b1;
              rom_addr_d  = addr_q[14:0];
              rom_wdata_d = {hi_q, rx_data};
              addr_d      = addr_q + 16'd1;
              if (addr_q == len_q - 16'd1) begin
                state_d  = S_IDLE;
                loaded_d = 1'b1;
              end else state_d = S_DATA_HI;
            end
          endcase
        end
      end
      S_RUN_RST: begin
        if (cmd_stop) state_d = S_IDLE;
        else begin
          state_d  = S_RUN;
          cycles_d = 32'd0;
          halted_d = 1'b0;
          pc_d1_d  = 15'd0;
          pc_d2_d  = 15'd0;
          hist_d   = 2'd0;
          match_d  = 8'd0;
        end
      end
      default: begin
        if (cmd_stop) state_d = S_IDLE;
        else begin
          if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
          pc_d1_d = cpu_pc;
          pc_d2_d = pc_d1_q;
          if (hist_q != 2'd2) hist_d = hist_q + 2'd1;
          // A 1- or 2-instruction self-jump makes pc repeat with period <= 2.
          if (hist_q == 2'd2 && cpu_pc == pc_d2_q) begin
            match_d = match_q + 8'd1;
            if ((9'(match_q) + 9'd1) == 9'(HALT_CYCLES)) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end else match_d = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      match_q     <= '0;
      pc_d1_q     <= '0;
      pc_d2_q     <= '0;
      hist_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cycles_q    <= '0;
      loaded_q    <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      match_q     <= match_d;
      pc_d1_q     <= pc_d1_d;
      pc_d2_q     <= pc_d2_d;
      hist_q      <= hist_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cycles_q    <= cycles_d;
      loaded_q    <= loaded_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Bench for hack_run_ctrl: per-cycle vector records plus a ROM-write scoreboard.
module tb_hack_run_ctrl;
  logic        clock = 0, reset = 1;
  logic        cmd_load = 0, cmd_run = 0, cmd_stop = 0, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_ready, rom_we, cpu_reset, mem_we, loaded, halted, err;
  logic [14:0] rom_addr, cpu_pc = 0;
  logic [15:0] rom_wdata;
  logic        cpu_writeM = 0;
  logic [31:0] cycles_run;

  int checks = 0, failures = 0;
  logic [30:0] sbq[$];

  hack_run_ctrl #(.HALT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cmd_stop(cmd_stop), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_pc(cpu_pc), .cpu_writeM(cpu_writeM),
    .cpu_reset(cpu_reset), .mem_we(mem_we), .cycles_run(cycles_run),
    .loaded(loaded), .halted(halted), .err(err));

  always #5 clock = ~clock;

  typedef struct {
    logic ld, run, stp, vld;
    logic [7:0] dat;
    logic [14:0] pc;
    logic wm, e_rdy, e_crst, e_mwe, push;
    logic [14:0] e_addr;
    logic [15:0] e_data;
  } vec_t;

  function automatic vec_t mk(logic ld, logic run, logic stp, logic vld, logic [7:0] dat,
                              logic [14:0] pc, logic wm, logic e_rdy, logic e_crst,
                              logic e_mwe, logic push, logic [14:0] e_addr, logic [15:0] e_data);
    vec_t v;
    v.ld = ld; v.run = run; v.stp = stp; v.vld = vld; v.dat = dat; v.pc = pc; v.wm = wm;
    v.e_rdy = e_rdy; v.e_crst = e_crst; v.e_mwe = e_mwe; v.push = push;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Loading-state vectors: IDLE shows no ready, the four byte states do.
  task automatic apply(input vec_t v);
    cmd_load = v.ld; cmd_run = v.run; cmd_stop = v.stp;
    rx_valid = v.vld; rx_data = v.dat; cpu_pc = v.pc; cpu_writeM = v.wm;
    @(negedge clock);
    chk("rx_ready", 32'(rx_ready), 32'(v.e_rdy));
    chk("cpu_reset", 32'(cpu_reset), 32'(v.e_crst));
    chk("mem_we", 32'(mem_we), 32'(v.e_mwe));
    if (v.push) sbq.push_back({v.e_addr, v.e_data});
    @(posedge clock); #1;
    cmd_load = 0; cmd_run = 0; cmd_stop = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply(mk(0,0,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
  endtask

  task automatic send(input logic [7:0] b, input logic push, input logic [14:0] a, input logic [15:0] d);
    apply(mk(0,0,0, 1,b, 0,1, 1,1,0, push,a,d));
  endtask

  // Scoreboard: every rom_we pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (!reset && rom_we) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rom_we_unexpected: got addr 0x%0h data 0x%0h expected no write", rom_addr, rom_wdata);
      end else begin
        logic [30:0] e;
        e = sbq.pop_front();
        checks++;
        if ({rom_addr, rom_wdata} !== e) begin
          failures++;
          $display("FAIL rom_write: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                   rom_addr, rom_wdata, e[30:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [4:0] pcs[9] = '{0,1,2,3,4,3,4,3,4};
    logic hit;

    // Reset values
    cpu_writeM = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_rom_we", 32'(rom_we), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_wdata", 32'(rom_wdata), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cycles", cycles_run, 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err), 0);
    reset = 0;

    // 3-word load with a 3-cycle gap after byte 4
    tbl.push_back(mk(1,0,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'h00, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'h03, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'h12, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'h34, 0,1, 1,1,0, 1,0,16'h1234));
    tbl.push_back(mk(0,0,0, 0,8'h55, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,8'h55, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,8'h55, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'hAB, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'hCD, 0,1, 1,1,0, 1,1,16'hABCD));
    tbl.push_back(mk(0,0,0, 1,8'h00, 0,1, 1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,8'h07, 0,1, 1,1,0, 1,2,16'h0007));
    tbl.push_back(mk(0,0,0, 1,8'h99, 0,1, 0,1,0, 0,0,0));
    foreach (tbl[i]) apply(tbl[i]);
    chk("load_loaded", 32'(loaded), 1);
    chk("load_sb_drained", 32'(sbq.size()), 0);

    // Zero-length image
    apply(mk(1,0,0, 0,8'h00, 0,0, 0,1,0, 0,0,0));
    send(8'h00, 0,0,0);
    send(8'h00, 0,0,0);
    chk("n0_loaded", 32'(loaded), 1);
    chk("n0_rx_ready", 32'(rx_ready), 0);

    // Bad length 0x8001
    apply(mk(1,0,0, 0,8'h00, 0,0, 0,1,0, 0,0,0));
    send(8'h80, 0,0,0);
    send(8'h01, 0,0,0);
    idle_cycles(2);
    chk("bad_err", 32'(err), 1);
    chk("bad_loaded", 32'(loaded), 0);
    chk("bad_rx_ready", 32'(rx_ready), 0);

    // Largest legal length 0x8000 enters DATA_HI; stop aborts it
    apply(mk(1,0,0, 0,8'h00, 0,0, 0,1,0, 0,0,0));
    send(8'h80, 0,0,0);
    send(8'h00, 0,0,0);
    chk("max_err", 32'(err), 0);
    apply(mk(0,0,1, 0,8'h00, 0,0, 1,1,0, 0,0,0));
    chk("max_stop_ready", 32'(rx_ready), 0);

    // Abort after 2 words of a 4-word image, mid third word
    apply(mk(1,0,0, 0,8'h00, 0,0, 0,1,0, 0,0,0));
    send(8'h00, 0,0,0);
    send(8'h04, 0,0,0);
    send(8'h11, 0,0,0);
    send(8'h22, 1,0,16'h1122);
    send(8'h33, 0,0,0);
    send(8'h44, 1,1,16'h3344);
    send(8'h55, 0,0,0);
    apply(mk(0,0,1, 1,8'h66, 0,1, 1,1,0, 0,0,0));
    for (int i = 0; i < 3; i++) apply(mk(0,0,0, 1,8'h77, 0,1, 0,1,0, 0,0,0));
    chk("abort_loaded", 32'(loaded), 0);
    chk("abort_sb_drained", 32'(sbq.size()), 0);

    // Coincident stop+run in IDLE stays in IDLE
    apply(mk(0,1,1, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    apply(mk(0,0,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    apply(mk(0,0,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));

    // Run until the 2-instruction loop at pc 3/4 is detected
    tbl.delete();
    tbl.push_back(mk(0,1,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0,0,0, 0,8'h00, 15'(pcs[i]), logic'(i % 2), 0,0,logic'(i % 2), 0,0,0));
    tbl.push_back(mk(0,0,0, 0,8'h00, 3,1, 0,1,0, 0,0,0));
    foreach (tbl[i]) apply(tbl[i]);
    chk("run_halted", 32'(halted), 1);
    chk("run_cycles", cycles_run, 9);

    // Load from HALT clears halted
    apply(mk(1,0,0, 0,8'h00, 0,0, 0,1,0, 0,0,0));
    chk("halt_load_halted", 32'(halted), 0);
    apply(mk(0,0,1, 0,8'h00, 0,0, 1,1,0, 0,0,0));

    // Reset mid-RUN at cycles_run == 100
    apply(mk(0,1,0, 0,8'h00, 0,1, 0,1,0, 0,0,0));
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (cycles_run == 100) begin hit = 1; break; end
      cpu_pc = 15'(i + 10);
      cpu_writeM = 1;
      @(posedge clock); #1;
    end
    chk("mid_run_reached", 32'(hit), 1);
    chk("mid_run_mem_we", 32'(mem_we), 1);
    reset = 1;
    @(posedge clock); #1;
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 1);
    chk("mid_rst_cycles", cycles_run, 0);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    reset = 0;
    idle_cycles(2);
    chk("final_sb_drained", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
